// File: rtl/uart_pkg.sv
// Shared state encoding and parity helper for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Zero-extending a narrower word to 9 bits leaves its parity unchanged.
    function automatic logic par_bit(input logic [8:0] word, input logic odd);
        return odd ? ~^word : ^word;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit word FIFO, DEPTH x DATA_W: push visible to pop from the next clk, no bypass.
// Full FIFO drops pushes; pop on empty is ignored.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a small word FIFO; frames go out back-to-back on BCLK ticks.
// Line and busy are registered on tick edges; wr_ready drops only while the FIFO is full.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   rst,
    input  logic                   BCLK,
    input  logic                   wr_valid,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    output logic                   tx_data,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int BW = $clog2(DATA_W);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] pop_data;
    logic [BW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic              par_q;
    logic              pop;
    logic              full;
    logic              empty;
    logic              last_bit;
    logic              last_stop;
    logic              shift;
    logic              tx_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    assign wr_ready  = ~full;
    assign last_bit  = (bit_cnt == BW'(DATA_W - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign shift     = BCLK && ((state == START) || ((state == DATA) && !last_bit));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (BCLK) begin
            case (state)
                IDLE:    if (!empty) state_nxt = START;
                START:   state_nxt = DATA;
                DATA:    if (last_bit) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:  state_nxt = STOP;
                STOP:    if (last_stop) state_nxt = empty ? IDLE : START;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A word is popped either from IDLE or on the final stop tick, so frames abut.
    always_comb begin
        pop      = 1'b0;
        tx_nxt   = tx_data;
        busy_nxt = busy;
        done_nxt = 1'b0;
        if (BCLK) begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        tx_nxt   = 1'b0;
                        busy_nxt = 1'b1;
                    end
                end
                START:  tx_nxt = shreg[0];
                DATA:   tx_nxt = !last_bit ? shreg[0] : ((PARITY_EN != 0) ? par_q : 1'b1);
                PARITY: tx_nxt = 1'b1;
                STOP: begin
                    if (last_stop) begin
                        done_nxt = 1'b1;
                        if (!empty) begin
                            pop    = 1'b1;
                            tx_nxt = 1'b0;
                        end else begin
                            busy_nxt = 1'b0;
                        end
                    end
                end
                default: tx_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tx_data  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            shreg    <= '0;
            par_q    <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else if (rst) begin
            tx_data  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            shreg    <= '0;
            par_q    <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            tx_data <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            if (pop) begin
                shreg <= pop_data;
                par_q <= par_bit(9'(pop_data), PARITY_ODD != 0);
            end else if (shift) begin
                shreg <= shreg >> 1;
            end
            if (BCLK && (state == START)) begin
                bit_cnt <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state != STOP) begin
                stop_cnt <= 1'b0;
            end else if (BCLK) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: four instances (default, even parity, odd parity, 7 data + 2 stop bits).
module tb_uart_tx_fifo_cfg;

    localparam int CDW [4] = '{8, 8, 8, 7};
    localparam int CPE [4] = '{0, 1, 1, 0};
    localparam int CPO [4] = '{0, 0, 1, 0};
    localparam int CSB [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       arst_n;
    logic       rst;
    logic       BCLK;
    logic       wr_valid;
    logic [8:0] wr_data;

    logic [3:0]      rdy_v, tx_v, busy_v, done_v;
    logic [3:0][2:0] cnt_v;
    logic [3:0]      t_tx, t_busy, t_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_cfg #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .DEPTH(4)) u_dut0 (
        .clk(clk), .arst_n(arst_n), .rst(rst), .BCLK(BCLK), .wr_valid(wr_valid), .wr_data(wr_data[7:0]),
        .wr_ready(rdy_v[0]), .tx_data(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .fifo_count(cnt_v[0]));
    uart_tx_fifo_cfg #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .arst_n(arst_n), .rst(rst), .BCLK(BCLK), .wr_valid(wr_valid), .wr_data(wr_data[7:0]),
        .wr_ready(rdy_v[1]), .tx_data(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .fifo_count(cnt_v[1]));
    uart_tx_fifo_cfg #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .DEPTH(4)) u_dut2 (
        .clk(clk), .arst_n(arst_n), .rst(rst), .BCLK(BCLK), .wr_valid(wr_valid), .wr_data(wr_data[7:0]),
        .wr_ready(rdy_v[2]), .tx_data(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .fifo_count(cnt_v[2]));
    uart_tx_fifo_cfg #(.DATA_W(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .DEPTH(4)) u_dut3 (
        .clk(clk), .arst_n(arst_n), .rst(rst), .BCLK(BCLK), .wr_valid(wr_valid), .wr_data(wr_data[6:0]),
        .wr_ready(rdy_v[3]), .tx_data(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]), .fifo_count(cnt_v[3]));

    // Reference: a queue of words plus the queue of line levels still to be sent in the current frame.
    logic [8:0] mq [4][$];
    bit         mb [4][$];
    bit         m_tx [4];
    bit         m_busy [4];
    bit         m_done [4];

    function automatic logic [8:0] msk(input int d);
        return 9'h1FF >> (9 - CDW[d]);
    endfunction

    task automatic m_frame(input int d, input logic [8:0] w);
        mb[d].delete();
        for (int i = 0; i < CDW[d]; i++) mb[d].push_back(w[i]);
        if (CPE[d] != 0) mb[d].push_back((CPO[d] != 0) ? ~^w : ^w);
        for (int i = 0; i < CSB[d]; i++) mb[d].push_back(1'b1);
        m_tx[d]   = 1'b0;
        m_busy[d] = 1'b1;
    endtask

    always @(posedge clk or negedge arst_n) begin
        int pre;
        for (int d = 0; d < 4; d++) begin
            if (!arst_n || rst) begin
                mq[d].delete();
                mb[d].delete();
                m_tx[d]   = 1'b1;
                m_busy[d] = 1'b0;
                m_done[d] = 1'b0;
            end else begin
                pre       = mq[d].size();
                m_done[d] = 1'b0;
                if (BCLK) begin
                    if (mb[d].size() > 0) begin
                        m_tx[d] = mb[d].pop_front();
                    end else begin
                        if (m_busy[d]) m_done[d] = 1'b1;
                        if (pre > 0) begin
                            m_frame(d, mq[d].pop_front());
                        end else begin
                            m_busy[d] = 1'b0;
                            m_tx[d]   = 1'b1;
                        end
                    end
                end
                if (wr_valid && pre < 4) mq[d].push_back(wr_data & msk(d));
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [6:0] act, exp;
        for (int d = 0; d < 4; d++) begin
            act = {tx_v[d], busy_v[d], done_v[d], rdy_v[d], cnt_v[d]};
            exp = {m_tx[d], m_busy[d], m_done[d], 1'(mq[d].size() != 4), 3'(mq[d].size())};
            checks++;
            if (act != exp) begin
                errors++;
                $display("FAIL model dut%0d {tx,busy,done,rdy,cnt}: got %b, want %b (t=%0t)", d, act, exp, $time);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
        check_all();
    endtask

    task automatic tick();
        BCLK = 1'b1;
        cyc();
        BCLK = 1'b0;
        t_tx   = tx_v;
        t_busy = busy_v;
        t_done = done_v;
        repeat (15) cyc();
    endtask

    task automatic write_word(input logic [8:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        cyc();
        cyc();
        arst_n = 1'b1;
        cyc();
    endtask

    typedef struct {
        int         dut;
        logic [8:0] word;
        int         n;
        int         frame;
    } vec_t;

    vec_t tab [4];

    initial begin
        int got, bsy, dn, gaps, d;

        tab[0] = '{0, 9'h0A5, 10, 32'h34A};
        tab[1] = '{1, 9'h007, 11, 32'h60E};
        tab[2] = '{2, 9'h007, 11, 32'h40E};
        tab[3] = '{3, 9'h07F, 10, 32'h3FE};

        arst_n = 1'b1; rst = 1'b0; BCLK = 1'b0; wr_valid = 1'b0; wr_data = '0;
        #2;
        do_reset();
        check("reset_state", {tx_v[0], busy_v[0], done_v[0], rdy_v[0], cnt_v[0]}, 7'b1001000);

        // Single frames per configuration, line captured once per tick.
        for (int r = 0; r < 4; r++) begin
            d = tab[r].dut;
            do_reset();
            write_word(tab[r].word);
            got = 0; bsy = 0; dn = 0;
            for (int i = 0; i < tab[r].n; i++) begin
                tick();
                got[i] = t_tx[d];
                bsy += int'(t_busy[d]);
                dn  += int'(t_done[d]);
            end
            tick();
            check($sformatf("frame_bits_%0d", r), got, tab[r].frame);
            check($sformatf("busy_ticks_%0d", r), bsy, tab[r].n);
            check($sformatf("done_early_%0d", r), dn, 0);
            check($sformatf("frame_end_%0d", r), {t_done[d], t_busy[d], t_tx[d]}, 3'b101);
        end

        // Fill, stall the fifth write, then drain back-to-back.
        do_reset();
        for (int i = 0; i < 4; i++) write_word(9'(8'h31 + i));
        check("full_count", cnt_v[0], 4);
        check("full_ready", rdy_v[0], 0);
        wr_valid = 1'b1; wr_data = 9'h0C3;
        repeat (3) cyc();
        check("stall_count", cnt_v[0], 4);
        BCLK = 1'b1;
        cyc();
        BCLK = 1'b0;
        check("after_pop_count", cnt_v[0], 3);
        cyc();
        wr_valid = 1'b0;
        check("fifth_accepted", cnt_v[0], 4);
        dn = 0; gaps = 0;
        for (int i = 0; i < 55; i++) begin
            tick();
            dn += int'(t_done[0]);
            if (dn < 5 && !t_busy[0]) gaps++;
        end
        check("b2b_done_pulses", dn, 5);
        check("b2b_idle_gaps", gaps, 0);

        // Simultaneous push and pop at count 2.
        do_reset();
        write_word(9'h011);
        write_word(9'h022);
        wr_valid = 1'b1; wr_data = 9'h033; BCLK = 1'b1;
        cyc();
        wr_valid = 1'b0; BCLK = 1'b0;
        check("pushpop_count", cnt_v[0], 2);
        dn = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            dn += int'(t_done[0]);
        end
        check("pushpop_done", dn, 3);

        // Asynchronous reset in the middle of the data bits.
        do_reset();
        write_word(9'h000);
        write_word(9'h055);
        repeat (4) tick();
        check("pre_arst_line", {tx_v[0], busy_v[0]}, 2'b01);
        #2 arst_n = 1'b0;
        #1;
        check("arst_immediate", {tx_v[0], busy_v[0], done_v[0], cnt_v[0]}, 6'b100000);
        cyc();
        arst_n = 1'b1;
        cyc();

        // Synchronous clear in the middle of the data bits.
        write_word(9'h000);
        write_word(9'h055);
        repeat (4) tick();
        rst = 1'b1;
        check("rst_not_yet", {tx_v[0], busy_v[0]}, 2'b01);
        cyc();
        rst = 1'b0;
        check("rst_one_clk", {tx_v[0], busy_v[0], done_v[0], cnt_v[0]}, 6'b100000);
        check("rst_ready", rdy_v[0], 1);

        // Randomised traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 9'($urandom);
            BCLK     = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            cyc();
        end
        wr_valid = 1'b0; BCLK = 1'b0; rst = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
